// File: rtl/constraint_eval_pipe.sv
// ---------------------------------------------------------------------------
// constraint_eval_pipe
//
// Evaluates NCH independent constraint channels on one operand set per cycle.
// Each channel checks its WIDTH-bit operand against a 2-bit mode:
//   00 NONZERO  : operand has at least one bit set
//   01 ZERO     : operand is all zeros
//   10 ALLONES  : operand has every bit set
//   11 TAUT     : always satisfied
// A disabled channel always reports satisfied. The conjunction of all channel
// results is delivered as out_sat. The datapath is a two-register pipeline
// with valid/ready flow control on both sides. Running statistics count the
// results delivered and the satisfied ones, and a sticky flag records that
// any delivered result was unsatisfied.
//
// Ports
//   clk          : clock, all state on the rising edge
//   rst_n        : synchronous active-low reset
//   in_valid     : input operand set valid
//   in_ready     : block accepts the input this cycle
//   in_data      : NCH*WIDTH, channel k operand at [k*WIDTH +: WIDTH]
//   in_mode      : 2*NCH, channel k mode at [2k +: 2]
//   in_en        : NCH, per-channel enable
//   out_valid    : result valid
//   out_ready    : downstream accepts the result
//   out_sat      : AND of all channel results
//   out_ch_sat   : NCH, per-channel results
//   clr          : synchronous clear of the statistics
//   eval_cnt     : CNT_W, results delivered (saturating)
//   sat_cnt      : CNT_W, delivered results with out_sat=1 (saturating)
//   viol_sticky  : a delivered result had out_sat=0
// ---------------------------------------------------------------------------
module constraint_eval_pipe #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [2*NCH-1:0]     in_mode,
    input  logic [NCH-1:0]       in_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sat,
    output logic [NCH-1:0]       out_ch_sat,
    input  logic                 clr,
    output logic [CNT_W-1:0]     eval_cnt,
    output logic [CNT_W-1:0]     sat_cnt,
    output logic                 viol_sticky
);

    // Single-channel constraint decode. Mode 11 is a tautology, so it is a
    // plain constant rather than a reduction over the operand.
    function automatic logic eval_chan(input logic [WIDTH-1:0] op,
                                       input logic [1:0]       mode);
        logic r;
        case (mode)
            2'b00:   r = |op;
            2'b01:   r = (op == '0);
            2'b10:   r = &op;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic             inc);
        logic [CNT_W-1:0] r;
        r = c;
        if (inc && (c != '1)) begin
            r = c + CNT_W'(1);
        end
        return r;
    endfunction

    logic               adv_p1;
    logic               adv_p2;
    logic [NCH-1:0]     res_p0;
    logic [NCH-1:0]     res_p1;
    logic [NCH-1:0]     en_p1;
    logic               vld_p1;
    logic [NCH-1:0]     ch_sat_p1;
    logic               sat_p1;
    logic [NCH-1:0]     ch_sat_p2;
    logic               sat_p2;
    logic               vld_p2;
    logic               hs_out;

    // Flow control: a stage may load when it is empty or its contents move on.
    // in_ready never looks at in_valid, so there is no combinational loop
    // through an upstream that waits for ready.
    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    // ---- p0 -> p1: per-channel decode, each channel on its own slice ----
    always_comb begin
        res_p0 = '0;
        for (int k = 0; k < NCH; k++) begin
            res_p0[k] = eval_chan(in_data[k*WIDTH +: WIDTH], in_mode[2*k +: 2]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p1) begin
            res_p1 <= res_p0;
            en_p1  <= in_en;
        end
    end

    // ---- p1 -> p2: apply enables and form the conjunction ----
    assign ch_sat_p1 = res_p1 | ~en_p1;
    assign sat_p1    = &ch_sat_p1;

    // Result registers are zeroed when an empty slot moves through, so the
    // outputs read 0 whenever out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            ch_sat_p2 <= '0;
            sat_p2    <= 1'b0;
        end else if (adv_p2) begin
            vld_p2    <= vld_p1;
            ch_sat_p2 <= vld_p1 ? ch_sat_p1 : '0;
            sat_p2    <= vld_p1 && sat_p1;
        end
    end

    assign out_valid  = vld_p2;
    assign out_ch_sat = ch_sat_p2;
    assign out_sat    = sat_p2;

    // ---- statistics on the output handshake ----
    assign hs_out = vld_p2 && out_ready;

    // clr wins over a same-cycle handshake; that result is delivered but not
    // counted.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            eval_cnt    <= '0;
            sat_cnt     <= '0;
            viol_sticky <= 1'b0;
        end else if (hs_out) begin
            eval_cnt <= sat_inc(eval_cnt, 1'b1);
            sat_cnt  <= sat_inc(sat_cnt, sat_p2);
            if (!sat_p2) begin
                viol_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_constraint_eval_pipe.sv
// ---------------------------------------------------------------------------
// tb_constraint_eval_pipe
//
// Directed bench for constraint_eval_pipe with hand-computed expectations.
// Two instances share the same stimulus: u_dut (CNT_W=16) and u_sat
// (CNT_W=3) whose counters are used to observe saturation.
// ---------------------------------------------------------------------------
module tb_constraint_eval_pipe;

    localparam int W = 16;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [N*W-1:0]  in_data;
    logic [2*N-1:0]  in_mode;
    logic [N-1:0]    in_en;
    logic            out_ready;
    logic            clr;

    logic            in_ready;
    logic            out_valid;
    logic            out_sat;
    logic [N-1:0]    out_ch_sat;
    logic [15:0]     eval_cnt;
    logic [15:0]     sat_cnt;
    logic            viol_sticky;

    logic            s_in_ready;
    logic            s_out_valid;
    logic            s_out_sat;
    logic [N-1:0]    s_out_ch_sat;
    logic [2:0]      s_eval_cnt;
    logic [2:0]      s_sat_cnt;
    logic            s_viol_sticky;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    constraint_eval_pipe #(.WIDTH(W), .NCH(N), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_en(in_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
        .out_ch_sat(out_ch_sat), .clr(clr), .eval_cnt(eval_cnt),
        .sat_cnt(sat_cnt), .viol_sticky(viol_sticky)
    );

    constraint_eval_pipe #(.WIDTH(W), .NCH(N), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_en(in_en),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_sat(s_out_sat),
        .out_ch_sat(s_out_ch_sat), .clr(clr), .eval_cnt(s_eval_cnt),
        .sat_cnt(s_sat_cnt), .viol_sticky(s_viol_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Backpressure vector i: channel k operand nonzero iff bit k of (i+6),
    // so with mode 00 and all enabled the expected out_ch_sat is (i+6)&15.
    function automatic logic [N*W-1:0] pat(input int i);
        logic [N*W-1:0] d;
        logic [3:0]     v;
        d = '0;
        v = 4'(i + 6);
        for (int k = 0; k < N; k++) begin
            if (v[k]) d[k*W +: W] = 16'h0001 << (4 * k);
        end
        return d;
    endfunction

    // One transaction with out_ready=1; captures the result on the cycle
    // out_valid is due (two edges after the input handshake).
    task automatic single(input logic [N*W-1:0] d, input logic [2*N-1:0] m,
                          input logic [N-1:0] e, input string tag,
                          output logic [N-1:0] ch, output logic s);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_mode = m; in_en = e; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        ch = out_ch_sat;
        s  = out_sat;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench timeout");
    end

    logic [N-1:0] ch;
    logic         s;
    logic [3:0]   exp_q [10];
    int           idx;
    int           oidx;
    logic         hs_in;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_en = '0;
        out_ready = 1'b1; clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready_during", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sat",   32'(out_sat), 32'd0);
        chk("rst_out_ch",    32'(out_ch_sat), 32'd0);
        chk("rst_eval",      32'(eval_cnt), 32'd0);
        chk("rst_satcnt",    32'(sat_cnt), 32'd0);
        chk("rst_viol",      32'(viol_sticky), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);

        // Single transaction, latency 2
        in_valid = 1'b1;
        in_data  = {16'h0001, 16'h8000, 16'h00F0, 16'h0000};
        in_mode  = 8'h00;
        in_en    = 4'hF;
        #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_valid_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_c2", 32'(out_valid), 32'd1);
        chk("t1_ch",       32'(out_ch_sat), 32'hE);
        chk("t1_sat",      32'(out_sat), 32'd0);
        @(negedge clk);
        chk("t1_valid_c3", 32'(out_valid), 32'd0);
        chk("t1_eval",     32'(eval_cnt), 32'd1);
        chk("t1_satcnt",   32'(sat_cnt), 32'd0);
        chk("t1_viol",     32'(viol_sticky), 32'd1);

        // Mode coverage on channel 0; channels 1..3 are mode 11 (always 1)
        single({48'h0, 16'h0000}, 8'hFD, 4'hF, "m01_zero", ch, s);
        chk("m01_zero_ch", 32'(ch), 32'hF);
        chk("m01_zero_sat", 32'(s), 32'd1);
        single({48'h0, 16'h0005}, 8'hFD, 4'hF, "m01_five", ch, s);
        chk("m01_five_ch", 32'(ch), 32'hE);
        single({48'h0, 16'hFFFF}, 8'hFE, 4'hF, "m10_ffff", ch, s);
        chk("m10_ffff_ch", 32'(ch), 32'hF);
        single({48'h0, 16'hFFFE}, 8'hFE, 4'hF, "m10_fffe", ch, s);
        chk("m10_fffe_ch", 32'(ch), 32'hE);
        chk("m10_fffe_sat", 32'(s), 32'd0);
        single({48'h0, 16'h1234}, 8'hFF, 4'hF, "m11_any", ch, s);
        chk("m11_any_ch", 32'(ch), 32'hF);
        single({48'h0, 16'h0005}, 8'hFD, 4'hE, "m01_dis", ch, s);
        chk("m01_dis_ch", 32'(ch), 32'hF);
        single(64'h0, 8'h00, 4'h0, "all_dis", ch, s);
        chk("all_dis_ch", 32'(ch), 32'hF);
        chk("all_dis_sat", 32'(s), 32'd1);

        // Clear statistics before the backpressure run
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_eval", 32'(eval_cnt), 32'd0);
        chk("clr_viol", 32'(viol_sticky), 32'd0);

        // Backpressure: 10 back-to-back inputs, out_ready low for cycles 1..5
        for (int i = 0; i < 10; i++) exp_q[i] = 4'(i + 6);
        idx = 0;
        oidx = 0;
        in_mode = 8'h00;
        in_en = 4'hF;
        for (int c = 0; c < 60 && oidx < 10; c++) begin
            out_ready = !(c >= 1 && c <= 5);
            in_valid  = (idx < 10);
            in_data   = pat(idx);
            #1;
            if (c == 3) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (out_valid) begin
                chk("bp_ch",  32'(out_ch_sat), 32'(exp_q[oidx]));
                chk("bp_sat", 32'(out_sat), 32'(exp_q[oidx] == 4'hF));
                if (out_ready) oidx++;
            end
            hs_in = in_valid && in_ready;
            @(negedge clk);
            if (hs_in) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_accepted", 32'(idx), 32'd10);
        chk("bp_delivered", 32'(oidx), 32'd10);
        @(negedge clk);
        chk("bp_no_dup", 32'(out_valid), 32'd0);
        chk("bp_eval", 32'(eval_cnt), 32'd10);
        chk("bp_satcnt", 32'(sat_cnt), 32'd1);

        // Counter saturation: 9 satisfied results at full throughput
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        in_mode = 8'hFF;
        in_en = 4'hF;
        in_valid = 1'b1;
        repeat (9) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat16_eval", 32'(eval_cnt), 32'd9);
        chk("sat16_satcnt", 32'(sat_cnt), 32'd9);
        chk("sat3_eval", 32'(s_eval_cnt), 32'd7);
        chk("sat3_satcnt", 32'(s_sat_cnt), 32'd7);
        chk("sat3_viol", 32'(s_viol_sticky), 32'd0);

        // clr in the same cycle as an output handshake
        in_valid = 1'b1;
        in_data = {16'h0001, 16'h0001, 16'h0001, 16'h0000};
        in_mode = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clrhs_valid", 32'(out_valid), 32'd1);
        chk("clrhs_ch", 32'(out_ch_sat), 32'hE);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clrhs_eval", 32'(eval_cnt), 32'd0);
        chk("clrhs_satcnt", 32'(sat_cnt), 32'd0);
        chk("clrhs_viol", 32'(viol_sticky), 32'd0);
        chk("clrhs_consumed", 32'(out_valid), 32'd0);

        // Reset pulse with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstf_full_valid", 32'(out_valid), 32'd1);
        chk("rstf_full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstf_valid", 32'(out_valid), 32'd0);
        chk("rstf_in_ready", 32'(in_ready), 32'd1);
        chk("rstf_ch", 32'(out_ch_sat), 32'd0);
        chk("rstf_sat", 32'(out_sat), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstf_no_stale", 32'(out_valid), 32'd0);
        end
        chk("rstf_eval", 32'(eval_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
